// File: rtl/data_sram_like_responder_pkg.sv
// Shared types and constants for the data-side sram-like responder.
//   SRAM_SIZE_B/H/W : encodings of the 2-bit request size field
//   DSRAM_RESP_WD   : width of one queued response entry
//   dsram_resp_t    : queued response {is_wr, data, countdown}
//   dsram_strobe()  : byte-lane strobe for a size/low-address pair; zero when misaligned
package data_sram_like_responder_pkg;

  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;

  localparam int unsigned DSRAM_RESP_WD = 37;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } dsram_resp_t;

  // Size 3 falls into the word branch. Misaligned half/word gives an empty strobe,
  // so the request still completes but leaves the RAM untouched.
  function automatic logic [3:0] dsram_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    strb = 4'h0;
    case (size)
      SRAM_SIZE_B: strb = 4'b0001 << lo;
      SRAM_SIZE_H: strb = lo[0] ? 4'h0 : (4'b0011 << lo);
      default:     strb = (lo == 2'b00) ? 4'hf : 4'h0;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/data_sram_like_responder_if.sv
// sram-like data bus between the CPU (master) and the responder (slave).
//   req/wr/size/addr/wdata : request, driven by the master
//   addr_ok                : request accepted this cycle when req && addr_ok
//   data_ok/rdata          : in-order response, master must always take it
interface data_sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_like_responder_fifo.sv
// dsram_resp_fifo: in-order response queue with a per-entry latency countdown.
//   clk, resetn          : clock, synchronous active-low reset (empties queue)
//   push, push_is_wr,
//   push_data            : enqueue one response, countdown loaded with LATENCY-1
//   pop                  : dequeue the head (only when head_ready)
//   count                : number of occupied entries
//   head_ready           : queue nonempty and head countdown expired
//   head_is_wr, head_data: head entry contents
module dsram_resp_fifo
  import data_sram_like_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     push_is_wr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_ready,
  output logic                     head_is_wr,
  output logic [31:0]              head_data
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  dsram_resp_t            entry_q [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i].cnt <= 4'd0;
      end
    end else begin
      // Idle slots also count down; harmless since they are reloaded on push.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (entry_q[i].cnt != 4'd0) begin
          entry_q[i].cnt <= entry_q[i].cnt - 4'd1;
        end
      end
      if (push) begin
        entry_q[wr_ptr_q] <= '{is_wr: push_is_wr, data: push_data, cnt: CntInit};
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    count      = count_q;
    head_ready = (count_q != '0) && (entry_q[rd_ptr_q].cnt == 4'd0);
    head_is_wr = entry_q[rd_ptr_q].is_wr;
    head_data  = entry_q[rd_ptr_q].data;
  end

endmodule

// File: rtl/data_sram_like_responder.sv
// data_sram_like_responder: slave end of the CPU data sram-like bus. Word-wide RAM
// with byte strobes, plus a bounded in-order response queue with fixed latency.
//   clk    : clock, all logic on posedge
//   resetn : synchronous active-low reset; drops every outstanding response
//   bus    : sram-like slave port (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out)
// Parameters: ADDR_W word-address bits, DEPTH max outstanding (power of 2, >=2),
// LATENCY accept-to-data_ok cycles (1..15).
module data_sram_like_responder
  import data_sram_like_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  data_sram_like_responder_if.slave   bus
);

  localparam int unsigned Words = 1 << ADDR_W;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]       ram_q [Words];
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        strb;
  logic              accept;
  logic              data_ok;
  logic [CntW-1:0]   count;
  logic              head_ready;
  logic              head_is_wr;
  logic [31:0]       head_data;
  logic              unused_addr_hi;

  // Upper address bits are ignored, so the RAM aliases across the byte space.
  assign word_idx       = bus.addr[ADDR_W+1:2];
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
  assign strb           = dsram_strobe(bus.size, bus.addr[1:0]);

  // addr_ok depends only on registered occupancy, never on req.
  assign bus.addr_ok = resetn && (count < Full);
  assign accept      = bus.req && bus.addr_ok;

  // Reset is synchronous, so the head can still look ready during a reset cycle.
  assign data_ok     = resetn && head_ready;
  assign bus.data_ok = data_ok;
  assign bus.rdata   = (data_ok && !head_is_wr) ? head_data : 32'h0;

  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          ram_q[word_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  // The word is captured at accept even for writes (pre-write value); write
  // responses are masked to zero on output via head_is_wr.
  dsram_resp_fifo #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_resp_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_is_wr (bus.wr),
    .push_data  (ram_q[word_idx]),
    .pop        (data_ok),
    .count      (count),
    .head_ready (head_ready),
    .head_is_wr (head_is_wr),
    .head_data  (head_data)
  );

endmodule
